nn_model_sequencer: RTL and testbench
=====================================

// Module: nn_model_sequencer
// PURPOSE
//  Model manager between DPR host port and FPUBank. Latches a layer table
//  (opcode + region pointers) streamed by the host over mm_o/dpr_pass.
//  On ASN_INPUT/ASN_OUTPUT it runs a forward pass: one FPU op per layer,
//  then a copy of the final scratch into the output region.
//  Drives operand handles a..d shared with FPUBank; MMU serves the memory traffic.
// PARAMETERS
//  MAX_LAYERS  8  layer-table depth; layer_ctr width = $clog2(MAX_LAYERS+1)
// PORTS
//  clk         in   1             clock
//  rst_l       in   1             async active-low reset
//  mm_o        in   mm_state      host command
//  asn_opcode  in   layer_opcode  opcode for ASN_LAYER
//  dpr_pass    in   mem_handle_t  {region_begin,region_end}, ADDR_SIZE bits each
//  mm_pass     out  mem_handle_t  result handle to host
//  a,b,c,d     if   mem_handle    operand handles; block drives only their region field
//  fpu_op      out  op_id         FPU command, one-cycle pulse
//  fpu_avail   in   1             FPUBank idle/ready
//  fpu_done    in   1             FPUBank finished current op (pulse)
// BEHAVIOUR
//  Reset: state=WAIT, layer_ctr=0, num_layers=0, table/in/out ptrs=0,
//   mm_pass=0, a..d region=0, fpu_op=OP_NOP.
//  Register write protocol: a command sampled at edge k becomes state; the
//   payload is on dpr_pass/asn_opcode in the following cycle and is latched
//   at edge k+1 by that state. Config/idle states: next = mm_o (run-state
//   encodings on mm_o treated as WAIT).
//  WAIT: idle. ASN_MODEL entered from WAIT clears num_layers; otherwise it is
//   a no-op separator.
//  ASN_LAYER: if num_layers<MAX_LAYERS, table[num_layers].op<=asn_opcode and
//   num_layers++; else the command is ignored.
//  ASN_SCRATCH/SGRAD/WEIGHT/WGRAD/BIAS/BGRAD: store dpr_pass into the matching
//   field of table[num_layers-1]. Ignored when num_layers==0.
//   Gradient fields are stored only; they are unused in forward pass.
//  ASN_INPUT: latch in_ptr. ASN_OUTPUT: latch out_ptr, layer_ctr<=0, then
//   go to FWD_ISSUE; go to DONE if num_layers==0. mm_o is ignored while running.
//  Pointers are opaque: ADDR_SIZE-1 MSB=1 selects DPR, MSB=0 selects SDRAM
//   (decoded by MMU).
//  FWD_ISSUE: drive a=src, b=weight, c=bias, d=table[layer_ctr].scratch.
//   src = in_ptr for layer 0, else table[layer_ctr-1].scratch.
//   b,c=0 for RELU/SOFTMAX. When fpu_avail=1, pulse fpu_op for one cycle
//   (LINEAR->OP_LINEAR_FW, RELU->OP_RELU_FW, SOFTMAX->OP_SOFTMAX_FW), then FWD_WAIT.
//  FWD_WAIT: hold handles, fpu_op=OP_NOP; fpu_done seen only here. On fpu_done:
//   layer_ctr++; next is FWD_ISSUE if more layers remain, else COPY_ISSUE.
//  COPY_ISSUE/COPY_WAIT: same handshake with OP_COPY; a=last scratch, d=out_ptr.
//  DONE: one cycle, mm_pass<=out_ptr, handles->0; next WAIT.
//   The table is retained, so a new ASN_INPUT/ASN_OUTPUT reruns the model.
//   A host that holds mm_o=ASN_OUTPUT therefore reruns it.
//  mm_pass holds its value until the next DONE or reset.
//  fpu_done while not in *_WAIT is dropped. Async reset mid-run aborts at
//   once; FPUBank must also be reset.
// STRUCTURE
//  Shared package nn_pkg holds:
//   - mm_state: WAIT, ASN_MODEL, ASN_LAYER, ASN_SCRATCH, ASN_SGRAD, ASN_WEIGHT,
//     ASN_WGRAD, ASN_BIAS, ASN_BGRAD, ASN_INPUT, ASN_OUTPUT, FWD_ISSUE,
//     FWD_WAIT, COPY_ISSUE, COPY_WAIT, DONE
//   - layer_opcode: LINEAR, RELU, SOFTMAX
//   - op_id: OP_NOP, OP_LINEAR_FW, OP_RELU_FW, OP_SOFTMAX_FW, OP_COPY
//   - mem_handle_t {region_begin,region_end}; layer_entry_t struct
//  ADDR_SIZE comes from the memory defines. Sub-module: nn_layer_table
//   (register file, one write port, two read ports).
// TESTING
//  1 Program LINEAR layer:
//     scratch 42-50, sgrad 50-58, weight 5-34, wgrad 58-87, bias 34-42, bgrad 87-95
//     -> table[0] holds these; num_layers=1.
//  2 Program RELU layer: scratch 95-103, sgrad 103-111, then ASN_MODEL, WAIT
//     -> num_layers=2; table[1].op=RELU.
//  3 ASN_INPUT {DPR,0-7}, ASN_OUTPUT {DPR,7-14}, fpu_avail=1, done after 20 cycles
//     -> OP_LINEAR_FW a=in, b=5-34, c=34-42, d=42-50; then OP_RELU_FW a=42-50, d=95-103.
//  4 Continue scenario 3 -> OP_COPY a=95-103, d=DPR 7-14; DONE; mm_pass=out_ptr; WAIT.
//  5 Hold fpu_avail=0 for 10 cycles -> stays FWD_ISSUE, fpu_op=OP_NOP;
//     stray fpu_done in ISSUE is ignored.
//  6 Nine ASN_LAYER commands -> num_layers=8. Reset mid-run -> all outputs return to reset values.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared types for the neural-network model manager: host command states,
// layer opcodes, FPU operation ids and memory-region handles.
package nn_pkg;

  localparam int ADDR_SIZE = 16;

  typedef enum logic [3:0] {
    WAIT        = 4'd0,
    ASN_MODEL   = 4'd1,
    ASN_LAYER   = 4'd2,
    ASN_SCRATCH = 4'd3,
    ASN_SGRAD   = 4'd4,
    ASN_WEIGHT  = 4'd5,
    ASN_WGRAD   = 4'd6,
    ASN_BIAS    = 4'd7,
    ASN_BGRAD   = 4'd8,
    ASN_INPUT   = 4'd9,
    ASN_OUTPUT  = 4'd10,
    FWD_ISSUE   = 4'd11,
    FWD_WAIT    = 4'd12,
    COPY_ISSUE  = 4'd13,
    COPY_WAIT   = 4'd14,
    DONE        = 4'd15
  } mm_state;

  typedef enum logic [1:0] {
    LINEAR  = 2'd0,
    RELU    = 2'd1,
    SOFTMAX = 2'd2
  } layer_opcode;

  typedef enum logic [2:0] {
    OP_NOP        = 3'd0,
    OP_LINEAR_FW  = 3'd1,
    OP_RELU_FW    = 3'd2,
    OP_SOFTMAX_FW = 3'd3,
    OP_COPY       = 3'd4
  } op_id;

  typedef struct packed {
    logic [ADDR_SIZE-1:0] region_begin;
    logic [ADDR_SIZE-1:0] region_end;
  } mem_handle_t;

  typedef struct packed {
    layer_opcode op;
    mem_handle_t scratch;
    mem_handle_t sgrad;
    mem_handle_t weight;
    mem_handle_t wgrad;
    mem_handle_t bias;
    mem_handle_t bgrad;
  } layer_entry_t;

  // Run-state encodings arriving from the host are treated as idle.
  function automatic mm_state cfg_next(mm_state m);
    if (m > ASN_OUTPUT) begin
      return WAIT;
    end else begin
      return m;
    end
  endfunction

  function automatic op_id fwd_op(layer_opcode o);
    case (o)
      LINEAR:  return OP_LINEAR_FW;
      RELU:    return OP_RELU_FW;
      SOFTMAX: return OP_SOFTMAX_FW;
      default: return OP_NOP;
    endcase
  endfunction

endpackage

// File: rtl/nn_layer_table.sv
// Layer table register file: one field-granular write port driven by the
// host command state, two read ports serving the forward-pass sequencer.
module nn_layer_table
  import nn_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             wr_en,
  input  mm_state          wr_sel,
  input  logic [IDX_W-1:0] wr_idx,
  input  layer_opcode      wr_op,
  input  mem_handle_t      wr_handle,
  input  logic [IDX_W-1:0] rd0_idx,
  output layer_opcode      rd0_op,
  output mem_handle_t      rd0_scratch,
  output mem_handle_t      rd0_weight,
  output mem_handle_t      rd0_bias,
  input  logic [IDX_W-1:0] rd1_idx,
  output mem_handle_t      rd1_scratch
);

  layer_entry_t table_r [DEPTH];

  // The host command selects which column of the addressed entry is written
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      for (int i = 0; i < DEPTH; i++) begin
        table_r[i] <= '0;
      end
    end else if (wr_en) begin
      case (wr_sel)
        ASN_LAYER:   table_r[wr_idx].op      <= wr_op;
        ASN_SCRATCH: table_r[wr_idx].scratch <= wr_handle;
        ASN_SGRAD:   table_r[wr_idx].sgrad   <= wr_handle;
        ASN_WEIGHT:  table_r[wr_idx].weight  <= wr_handle;
        ASN_WGRAD:   table_r[wr_idx].wgrad   <= wr_handle;
        ASN_BIAS:    table_r[wr_idx].bias    <= wr_handle;
        ASN_BGRAD:   table_r[wr_idx].bgrad   <= wr_handle;
        default:     ;
      endcase
    end
  end

  assign rd0_op      = table_r[rd0_idx].op;
  assign rd0_scratch = table_r[rd0_idx].scratch;
  assign rd0_weight  = table_r[rd0_idx].weight;
  assign rd0_bias    = table_r[rd0_idx].bias;
  assign rd1_scratch = table_r[rd1_idx].scratch;

endmodule

// File: rtl/nn_model_sequencer.sv
// Model manager: latches a layer table from the host, then sequences one FPU
// op per layer followed by a copy of the final scratch into the output region.
module nn_model_sequencer
  import nn_pkg::*;
#(
  parameter int MAX_LAYERS = 8
) (
  input  logic        clk,
  input  logic        rst_l,
  input  mm_state     mm_o,
  input  layer_opcode asn_opcode,
  input  mem_handle_t dpr_pass,
  output mem_handle_t mm_pass,
  output mem_handle_t a,
  output mem_handle_t b,
  output mem_handle_t c,
  output mem_handle_t d,
  output op_id        fpu_op,
  input  logic        fpu_avail,
  input  logic        fpu_done
);

  localparam int CTR_W = $clog2(MAX_LAYERS + 1);
  localparam int IDX_W = (MAX_LAYERS > 1) ? $clog2(MAX_LAYERS) : 1;
  localparam logic [CTR_W-1:0] MAX_L    = CTR_W'(MAX_LAYERS);
  localparam logic [CTR_W-1:0] CTR_ONE  = CTR_W'(1);
  localparam logic [CTR_W-1:0] CTR_ZERO = CTR_W'(0);

  mm_state          state_r;
  logic [CTR_W-1:0] layer_ctr_r;
  logic [CTR_W-1:0] num_layers_r;
  mem_handle_t      in_ptr_r;
  mem_handle_t      out_ptr_r;
  layer_opcode      cur_op_r;

  logic [CTR_W-1:0] next_ctr_s;
  logic [CTR_W-1:0] last_ctr_s;
  logic [CTR_W-1:0] issue_ctr_s;
  logic             wr_en_s;
  logic [IDX_W-1:0] wr_idx_s;
  layer_opcode      rd0_op_s;
  mem_handle_t      rd0_scratch_s, rd0_weight_s, rd0_bias_s, rd1_scratch_s;
  mem_handle_t      iss_a_s, iss_b_s, iss_c_s;

  assign next_ctr_s = layer_ctr_r + CTR_ONE;
  assign last_ctr_s = num_layers_r - CTR_ONE;

  nn_layer_table #(
    .DEPTH(MAX_LAYERS),
    .IDX_W(IDX_W)
  ) u_table (
    .clk        (clk),
    .rst_l      (rst_l),
    .wr_en      (wr_en_s),
    .wr_sel     (state_r),
    .wr_idx     (wr_idx_s),
    .wr_op      (asn_opcode),
    .wr_handle  (dpr_pass),
    .rd0_idx    (issue_ctr_s[IDX_W-1:0]),
    .rd0_op     (rd0_op_s),
    .rd0_scratch(rd0_scratch_s),
    .rd0_weight (rd0_weight_s),
    .rd0_bias   (rd0_bias_s),
    .rd1_idx    (layer_ctr_r[IDX_W-1:0]),
    .rd1_scratch(rd1_scratch_s)
  );

  // Table write enable: payload is latched in the cycle the command state is held
  always_comb begin
    wr_en_s  = 1'b0;
    wr_idx_s = last_ctr_s[IDX_W-1:0];
    case (state_r)
      ASN_LAYER: begin
        wr_en_s  = (num_layers_r < MAX_L);
        wr_idx_s = num_layers_r[IDX_W-1:0];
      end
      ASN_SCRATCH, ASN_SGRAD, ASN_WEIGHT, ASN_WGRAD, ASN_BIAS, ASN_BGRAD: begin
        wr_en_s = (num_layers_r != CTR_ZERO);
      end
      default: begin
        wr_en_s = 1'b0;
      end
    endcase
  end

  // Operand handles for the layer about to be issued; rd1 holds the previous scratch
  always_comb begin
    if (state_r == ASN_OUTPUT) begin
      issue_ctr_s = CTR_ZERO;
    end else begin
      issue_ctr_s = next_ctr_s;
    end
    if (issue_ctr_s == CTR_ZERO) begin
      iss_a_s = in_ptr_r;
    end else begin
      iss_a_s = rd1_scratch_s;
    end
    if (rd0_op_s == LINEAR) begin
      iss_b_s = rd0_weight_s;
      iss_c_s = rd0_bias_s;
    end else begin
      iss_b_s = '0;
      iss_c_s = '0;
    end
  end

  // Sequencer: host configuration states, then forward pass and final copy
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_r      <= WAIT;
      layer_ctr_r  <= CTR_ZERO;
      num_layers_r <= CTR_ZERO;
      in_ptr_r     <= '0;
      out_ptr_r    <= '0;
      cur_op_r     <= LINEAR;
      mm_pass      <= '0;
      a            <= '0;
      b            <= '0;
      c            <= '0;
      d            <= '0;
      fpu_op       <= OP_NOP;
    end else begin
      fpu_op <= OP_NOP;
      case (state_r)
        WAIT: begin
          if (mm_o == ASN_MODEL) begin
            num_layers_r <= CTR_ZERO;
          end
          state_r <= cfg_next(mm_o);
        end
        ASN_LAYER: begin
          if (num_layers_r < MAX_L) begin
            num_layers_r <= num_layers_r + CTR_ONE;
          end
          state_r <= cfg_next(mm_o);
        end
        ASN_INPUT: begin
          in_ptr_r <= dpr_pass;
          state_r  <= cfg_next(mm_o);
        end
        ASN_OUTPUT: begin
          out_ptr_r   <= dpr_pass;
          layer_ctr_r <= CTR_ZERO;
          if (num_layers_r == CTR_ZERO) begin
            state_r <= DONE;
          end else begin
            a        <= iss_a_s;
            b        <= iss_b_s;
            c        <= iss_c_s;
            d        <= rd0_scratch_s;
            cur_op_r <= rd0_op_s;
            state_r  <= FWD_ISSUE;
          end
        end
        FWD_ISSUE: begin
          if (fpu_avail) begin
            fpu_op  <= fwd_op(cur_op_r);
            state_r <= FWD_WAIT;
          end
        end
        FWD_WAIT: begin
          if (fpu_done) begin
            layer_ctr_r <= next_ctr_s;
            if (next_ctr_s < num_layers_r) begin
              a        <= iss_a_s;
              b        <= iss_b_s;
              c        <= iss_c_s;
              d        <= rd0_scratch_s;
              cur_op_r <= rd0_op_s;
              state_r  <= FWD_ISSUE;
            end else begin
              a       <= rd1_scratch_s;
              b       <= '0;
              c       <= '0;
              d       <= out_ptr_r;
              state_r <= COPY_ISSUE;
            end
          end
        end
        COPY_ISSUE: begin
          if (fpu_avail) begin
            fpu_op  <= OP_COPY;
            state_r <= COPY_WAIT;
          end
        end
        COPY_WAIT: begin
          if (fpu_done) begin
            state_r <= DONE;
          end
        end
        DONE: begin
          mm_pass <= out_ptr_r;
          a       <= '0;
          b       <= '0;
          c       <= '0;
          d       <= '0;
          state_r <= WAIT;
        end
        default: begin
          state_r <= cfg_next(mm_o);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nn_model_sequencer.sv
// Directed + randomized bench: host programs a layer table, the bench plays
// FPUBank and checks every issued op against a table-level reference model.
module tb_nn_model_sequencer;
  import nn_pkg::*;

  localparam int MAXL = 8;
  localparam logic [ADDR_SIZE-1:0] DPR = {1'b1, {(ADDR_SIZE-1){1'b0}}};

  typedef struct { mm_state cmd; mem_handle_t h; layer_opcode op; } host_cmd_t;
  typedef struct { op_id op; mem_handle_t a, b, c, d; } fpu_req_t;

  logic        clk = 1'b0;
  logic        rst_l;
  mm_state     mm_o;
  layer_opcode asn_opcode;
  mem_handle_t dpr_pass;
  mem_handle_t mm_pass, a, b, c, d;
  op_id        fpu_op;
  logic        fpu_avail, fpu_done;

  int tests = 0;
  int fails = 0;

  nn_model_sequencer #(.MAX_LAYERS(MAXL)) dut (
    .clk(clk), .rst_l(rst_l), .mm_o(mm_o), .asn_opcode(asn_opcode),
    .dpr_pass(dpr_pass), .mm_pass(mm_pass), .a(a), .b(b), .c(c), .d(d),
    .fpu_op(fpu_op), .fpu_avail(fpu_avail), .fpu_done(fpu_done)
  );

  always #5 clk = ~clk;

  // Reference model: the layer table as the host sees it
  layer_opcode m_op [MAXL];
  mem_handle_t m_scr [MAXL];
  mem_handle_t m_wt [MAXL];
  mem_handle_t m_bs [MAXL];
  int          m_num;
  mem_handle_t m_in, m_out;
  host_cmd_t   prog[$];

  function automatic mem_handle_t hnd(logic [ADDR_SIZE-1:0] lo, logic [ADDR_SIZE-1:0] hi);
    mem_handle_t h;
    h.region_begin = lo;
    h.region_end   = hi;
    return h;
  endfunction

  function automatic mem_handle_t rnd_h();
    return hnd(ADDR_SIZE'($urandom), ADDR_SIZE'($urandom));
  endfunction

  function automatic op_id exp_op(layer_opcode o);
    case (o)
      LINEAR:  return OP_LINEAR_FW;
      RELU:    return OP_RELU_FW;
      default: return OP_SOFTMAX_FW;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < MAXL; i++) begin
      m_op[i] = LINEAR; m_scr[i] = '0; m_wt[i] = '0; m_bs[i] = '0;
    end
    m_num = 0; m_in = '0; m_out = '0;
  endtask

  task automatic chk_h(string tag, mem_handle_t got, mem_handle_t exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_op(string tag, op_id got, op_id exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_int(string tag, int got, int exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic add(mm_state cmd, mem_handle_t h, layer_opcode op);
    host_cmd_t hc;
    hc.cmd = cmd; hc.h = h; hc.op = op;
    prog.push_back(hc);
  endtask

  // Back-to-back host commands: each payload rides with the following command
  task automatic play();
    mem_handle_t ph = '0;
    layer_opcode po = LINEAR;
    mm_state     prev = WAIT;
    foreach (prog[i]) begin
      @(negedge clk);
      mm_o = prog[i].cmd; dpr_pass = ph; asn_opcode = po;
      case (prog[i].cmd)
        ASN_MODEL:   if (prev == WAIT) m_num = 0;
        ASN_LAYER:   if (m_num < MAXL) begin m_op[m_num] = prog[i].op; m_num++; end
        ASN_SCRATCH: if (m_num > 0) m_scr[m_num-1] = prog[i].h;
        ASN_WEIGHT:  if (m_num > 0) m_wt[m_num-1] = prog[i].h;
        ASN_BIAS:    if (m_num > 0) m_bs[m_num-1] = prog[i].h;
        ASN_INPUT:   m_in = prog[i].h;
        ASN_OUTPUT:  m_out = prog[i].h;
        default:     ;
      endcase
      prev = prog[i].cmd;
      ph = prog[i].h; po = prog[i].op;
    end
    @(negedge clk);
    mm_o = WAIT; dpr_pass = ph; asn_opcode = po;
    prog.delete();
  endtask

  // Acts as FPUBank; abort_after>0 returns once that many ops were seen
  task automatic run_model(int lat, int hold, int abort_after);
    fpu_req_t q[$];
    fpu_req_t r;
    int  seen = 0;
    int  cd = 0;
    int  budget = 0;
    int  hl = hold;
    bit  fin = 1'b0;
    for (int i = 0; i < m_num; i++) begin
      r.op = exp_op(m_op[i]);
      if (i == 0) r.a = m_in; else r.a = m_scr[i-1];
      if (m_op[i] == LINEAR) begin r.b = m_wt[i]; r.c = m_bs[i]; end
      else begin r.b = '0; r.c = '0; end
      r.d = m_scr[i];
      q.push_back(r);
    end
    if (m_num > 0) begin
      r.op = OP_COPY; r.a = m_scr[m_num-1]; r.b = '0; r.c = '0; r.d = m_out;
      q.push_back(r);
    end
    fpu_avail = (hl == 0);
    fpu_done  = 1'b0;
    while (!fin && budget < 3000) begin
      @(negedge clk);
      budget++;
      fpu_done = 1'b0;
      if (hl > 0) begin
        hl--;
        chk_op("hold_nop", fpu_op, OP_NOP);
        if (hl == 5) fpu_done = 1'b1;
        if (hl == 0) fpu_avail = 1'b1;
      end else if (fpu_op != OP_NOP) begin
        if (seen < q.size()) begin
          chk_op($sformatf("op%0d", seen), fpu_op, q[seen].op);
          chk_h($sformatf("a%0d", seen), a, q[seen].a);
          chk_h($sformatf("b%0d", seen), b, q[seen].b);
          chk_h($sformatf("c%0d", seen), c, q[seen].c);
          chk_h($sformatf("d%0d", seen), d, q[seen].d);
        end else begin
          chk_op("extra_op", fpu_op, OP_NOP);
        end
        seen++;
        cd = lat;
        if (abort_after > 0 && seen == abort_after) fin = 1'b1;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) fpu_done = 1'b1;
      end else if (seen >= q.size()) begin
        fin = 1'b1;
      end
    end
    chk_int("run_in_budget", int'(fin), 1);
    if (abort_after == 0) begin
      chk_int("op_count", seen, q.size());
      @(negedge clk);
      @(negedge clk);
      chk_h("mm_pass", mm_pass, m_out);
      chk_h("a_idle", a, '0);
      chk_h("d_idle", d, '0);
      chk_op("op_idle", fpu_op, OP_NOP);
    end
  endtask

  initial begin
    rst_l = 1'b0; mm_o = WAIT; asn_opcode = LINEAR; dpr_pass = '0;
    fpu_avail = 1'b1; fpu_done = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk_h("rst_mm_pass", mm_pass, '0);
    chk_h("rst_a", a, '0);
    chk_h("rst_b", b, '0);
    chk_h("rst_c", c, '0);
    chk_h("rst_d", d, '0);
    chk_op("rst_fpu_op", fpu_op, OP_NOP);
    rst_l = 1'b1;

    // LINEAR + RELU model, DPR input/output, 20-cycle FPU latency
    add(ASN_LAYER, '0, LINEAR);
    add(ASN_SCRATCH, hnd(16'd42, 16'd50), LINEAR);
    add(ASN_SGRAD, hnd(16'd50, 16'd58), LINEAR);
    add(ASN_WEIGHT, hnd(16'd5, 16'd34), LINEAR);
    add(ASN_WGRAD, hnd(16'd58, 16'd87), LINEAR);
    add(ASN_BIAS, hnd(16'd34, 16'd42), LINEAR);
    add(ASN_BGRAD, hnd(16'd87, 16'd95), LINEAR);
    add(ASN_LAYER, '0, RELU);
    add(ASN_SCRATCH, hnd(16'd95, 16'd103), RELU);
    add(ASN_SGRAD, hnd(16'd103, 16'd111), RELU);
    add(ASN_MODEL, '0, LINEAR);
    play();
    add(ASN_INPUT, hnd(DPR | 16'd0, DPR | 16'd7), LINEAR);
    add(ASN_OUTPUT, hnd(DPR | 16'd7, DPR | 16'd14), LINEAR);
    play();
    run_model(20, 0, 0);

    // Rerun with FPU busy for 10 cycles and a stray done while issuing
    add(ASN_INPUT, rnd_h(), LINEAR);
    add(ASN_OUTPUT, rnd_h(), LINEAR);
    play();
    run_model(int'($urandom_range(1, 5)), 10, 0);

    // New model with nine layer commands; the ninth is dropped
    add(ASN_MODEL, '0, LINEAR);
    for (int i = 0; i < 9; i++) begin
      add(ASN_LAYER, '0, layer_opcode'($urandom_range(0, 2)));
      add(ASN_SCRATCH, rnd_h(), LINEAR);
      add(ASN_WEIGHT, rnd_h(), LINEAR);
      add(ASN_BIAS, rnd_h(), LINEAR);
    end
    add(ASN_INPUT, rnd_h(), LINEAR);
    add(ASN_OUTPUT, rnd_h(), LINEAR);
    play();
    chk_int("model_num_layers", m_num, MAXL);
    run_model(int'($urandom_range(1, 4)), 0, 0);

    // Abort a rerun with asynchronous reset
    add(ASN_INPUT, rnd_h(), LINEAR);
    add(ASN_OUTPUT, rnd_h(), LINEAR);
    play();
    run_model(3, 0, 3);
    #1 rst_l = 1'b0;
    #1;
    chk_h("abort_mm_pass", mm_pass, '0);
    chk_h("abort_a", a, '0);
    chk_h("abort_b", b, '0);
    chk_h("abort_c", c, '0);
    chk_h("abort_d", d, '0);
    chk_op("abort_fpu_op", fpu_op, OP_NOP);
    model_reset();
    fpu_done = 1'b0;
    mm_o = WAIT;
    @(negedge clk);
    rst_l = 1'b1;

    // Empty table: field write ignored, run goes straight to DONE
    add(ASN_SCRATCH, rnd_h(), LINEAR);
    add(ASN_INPUT, rnd_h(), LINEAR);
    add(ASN_OUTPUT, rnd_h(), LINEAR);
    play();
    run_model(2, 0, 0);

    // Single SOFTMAX layer whose scratch was never assigned
    add(ASN_LAYER, '0, SOFTMAX);
    add(ASN_WEIGHT, rnd_h(), SOFTMAX);
    add(ASN_INPUT, rnd_h(), LINEAR);
    add(ASN_OUTPUT, rnd_h(), LINEAR);
    play();
    run_model(int'($urandom_range(1, 6)), 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
